// File: rtl/popcount_pkg.sv
// Shared types and derived-size helpers for the popcount expander.
// Default derived sizes assume a 512-bit mask split into 128-bit beats.
package popcount_pkg;

  function automatic int idx_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  localparam int N_DEFAULT         = 512;
  localparam int BEATWIDTH_DEFAULT = 128;
  localparam int BEATNUM_DEFAULT   = (N_DEFAULT + BEATWIDTH_DEFAULT - 1) / BEATWIDTH_DEFAULT;
  localparam int REM_DEFAULT       = N_DEFAULT % BEATWIDTH_DEFAULT;
  localparam int IDXW_DEFAULT      = idx_width(BEATNUM_DEFAULT);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } expander_state_e;

endpackage

// File: rtl/thermometer_encoder.sv
// Combinational thermometer code: the low k bits of mask are set, the rest clear.
module thermometer_encoder #(
  parameter int W = 128
) (
  input  logic [$clog2(W):0] k,
  output logic [W-1:0]       mask
);

  localparam int KW = $clog2(W) + 1;

  always_comb begin
    mask = '0;
    for (int j = 0; j < W; j++) begin
      mask[j] = (KW'(j) < k);
    end
  end

endmodule

// File: rtl/popcount_expander.sv
// Expands a population count into a thermometer mask streamed as BEATNUM beats.
// Optional POPCOUNT_EXPANDER_OVERFLOW_CHECK_EN adds overflow_o, flagging saturated counts.
//
// state  | meaning
// IDLE   | waiting for a count, no beat presented
// STREAM | presenting beat idx of the current mask
module popcount_expander
  import popcount_pkg::*;
#(
  parameter int N         = 512,
  parameter int BEATWIDTH = 128,
  localparam int BEATNUM  = (N + BEATWIDTH - 1) / BEATWIDTH,
  localparam int REM      = N % BEATWIDTH,
  localparam int IDXW     = idx_width(BEATNUM),
  localparam int CW       = $clog2(N) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [CW-1:0]        count_i,
  input  logic                 count_valid_i,
  output logic                 count_ready_o,
  output logic [BEATWIDTH-1:0] beat_o,
  output logic [IDXW-1:0]      beat_idx_o,
  output logic                 beat_last_o,
  output logic                 beat_valid_o,
  input  logic                 beat_ready_i
`ifdef POPCOUNT_EXPANDER_OVERFLOW_CHECK_EN
  ,
  output logic                 overflow_o
`endif
);

  localparam int KW       = $clog2(BEATWIDTH) + 1;
  localparam int REM_BITS = (REM == 0) ? BEATWIDTH : REM;
  localparam logic [BEATWIDTH-1:0] LAST_MASK = {BEATWIDTH{1'b1}} >> (BEATWIDTH - REM_BITS);

  expander_state_e       state;
  logic [CW-1:0]         remaining;
  logic [IDXW-1:0]       idx;
  logic                  streaming;
  logic                  last;
  logic                  accept;
  logic                  beat_hs;
  logic [CW-1:0]         sat;
  logic [KW-1:0]         k;
  logic [BEATWIDTH-1:0]  therm;

  assign streaming     = (state == STREAM);
  assign last          = streaming && (idx == IDXW'(BEATNUM - 1));
  // Ready reaches back combinationally so a new count can ride the last-beat handshake.
  assign count_ready_o = !streaming || (last && beat_ready_i);
  assign accept        = count_valid_i && count_ready_o;
  assign beat_hs       = streaming && beat_ready_i;
  assign sat           = (count_i > CW'(N)) ? CW'(N) : count_i;
  assign k             = (remaining > CW'(BEATWIDTH)) ? KW'(BEATWIDTH) : KW'(remaining);

  thermometer_encoder #(.W(BEATWIDTH)) u_therm (
    .k    (k),
    .mask (therm)
  );

  // The final-beat mask is redundant after saturation but guards against a bad remaining.
  always_comb begin
    beat_o = '0;
    if (streaming) begin
      beat_o = last ? (therm & LAST_MASK) : therm;
    end
  end

  assign beat_idx_o   = idx;
  assign beat_last_o  = last;
  assign beat_valid_o = streaming;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= IDLE;
      remaining <= '0;
      idx       <= '0;
    end else if (accept) begin
      state     <= STREAM;
      remaining <= sat;
      idx       <= '0;
    end else if (beat_hs) begin
      remaining <= (remaining > CW'(BEATWIDTH)) ? remaining - CW'(BEATWIDTH) : '0;
      if (last) begin
        state <= IDLE;
        idx   <= '0;
      end else begin
        idx   <= idx + IDXW'(1);
      end
    end
  end

`ifdef POPCOUNT_EXPANDER_OVERFLOW_CHECK_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      overflow_o <= 1'b0;
    end else begin
      overflow_o <= accept && (count_i > CW'(N));
    end
  end
`endif

endmodule

// File: doc/popcount_expander.md
Name: popcount_expander

Overview:
- Inverse of the popcount adder tree: takes a population count and streams the matching N-bit thermometer mask. The mask has `count` ones packed from bit 0 upward.
- Output is sliced into BEATNUM beats of BEATWIDTH bits over a valid/ready stream.
- Feeds mask-driven datapaths (channel enables, partial-tile masks) that consume bitvectors at tree granularity.
- Sequential: input handshake, beat counter, remaining-count register, backpressure hold.

Parameters:
- N, 512, mask width in bits.
- BEATWIDTH, 128, bits per output beat (tree branch width).
- BEATNUM, (N+BEATWIDTH-1)/BEATWIDTH, number of beats per mask; derived, do not override.
- REM, N%BEATWIDTH, valid bits in the final beat when nonzero; derived.
- IDXW, (BEATNUM>1)?$clog2(BEATNUM):1, beat index width; derived.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  synchronous active-low reset.
- count_i  in  $clog2(N)+1  requested number of ones.
- count_valid_i  in  1  count_i valid.
- count_ready_o  out  1  block accepts count_i.
- beat_o  out  BEATWIDTH  current mask slice; bit j is mask bit beat_idx_o*BEATWIDTH+j.
- beat_idx_o  out  IDXW  index of current beat.
- beat_last_o  out  1  current beat is beat BEATNUM-1.
- beat_valid_o  out  1  beat_o valid.
- beat_ready_i  in  1  consumer accepts beat.

Behaviour:
- Clock and reset: one clock (clk_i); reset is synchronous and active-low (rst_ni).
- Reset values: state=IDLE; beat_o=0; beat_idx_o=0; beat_last_o=0; beat_valid_o=0; remaining=0. count_ready_o is 1 from the first cycle after reset.
- FSM states: IDLE, STREAM.
- IDLE:
  - count_ready_o=1, beat_valid_o=0.
  - On count_valid_i, latch sat=min(count_i,N) into `remaining`, set idx=0, go to STREAM.
- STREAM:
  - beat_valid_o=1.
  - beat_o = thermometer(min(remaining,BEATWIDTH)), bits at index ≥k are 0.
  - Final beat with REM≠0: bits [BEATWIDTH-1:REM] are forced 0. They already are after saturation; the forcing is kept as a safety net.
- Beat handshake (beat_valid_o & beat_ready_i):
  - remaining ← remaining>BEATWIDTH ? remaining-BEATWIDTH : 0.
  - idx ← idx+1.
  - On the last beat, return to IDLE.
- Back-to-back transfers:
  - count_ready_o = IDLE | (STREAM & beat_last_o & beat_ready_i). This is a combinational path from beat_ready_i; it is documented and intended.
  - If a count is accepted on the last-beat handshake, go directly to STREAM with idx=0 and the new remaining. There are no bubble cycles.
- Latency: count accepted at cycle t gives the first beat valid at t+1. A full mask takes BEATNUM beat handshakes.
- Backpressure: while beat_valid_o & !beat_ready_i, beat_o, beat_idx_o and beat_last_o are held stable. Valid never drops without a handshake.
- Boundaries:
  - count_i=0 still emits BEATNUM all-zero beats.
  - count_i=N emits all-ones beats; the final beat is limited to REM bits.
  - count_i>N saturates to N.
  - BEATNUM=1: the single beat has beat_last_o=1.
- Reset mid-stream: the in-flight mask is discarded. All outputs return to reset values on the next edge.
- Arithmetic: `remaining` is $clog2(N)+1 bits, unsigned, with no wrap (saturating subtract).

Optional Feature:
- Macro: POPCOUNT_EXPANDER_OVERFLOW_CHECK_EN.
- Defined: adds output port overflow_o (1 bit, reset 0). It pulses high for exactly one cycle, the cycle after a count handshake where count_i>N. Saturation happens as normal.
- Undefined: no port, no comparator logic. Saturation still applies, because the min() is always present.

Decomposition:
- Shared package popcount_pkg holds:
  - localparams for BEATNUM, REM and IDXW computed from N/BEATWIDTH;
  - typedef expander_state_e {IDLE, STREAM};
  - function clog2-safe index width.
- One sub-module: thermometer_encoder.
  - Parameter W.
  - Input k [$clog2(W):0]; output [W-1:0] with bits below k set.
  - Purely combinational, instantiated once for beat_o generation.

Test Plan:
- N=512, BEATWIDTH=128, count=0 -> 4 beats of 0, idx 0..3, beat_last_o only on idx 3; count_ready_o high again the cycle after.
- N=512, count=200 -> beat0 all ones; beat1 = low 72 bits ones, upper 56 zero; beats 2,3 zero.
- N=300, BEATWIDTH=128, count=300 -> beats 0,1 all ones; beat2 low 44 ones, bits [127:44] zero, beat_last_o=1.
- N=512, count=130 with beat_ready_i low 3 cycles during beat1 -> beat_o=0x3, idx=1 stable for all stall cycles; count_ready_o=0.
- Back-to-back: count=512 then count=5 presented during the last beat with beat_ready_i=1 -> both accepted, no idle cycle, second mask beat0=0x1F.
- With macro, count=600 on N=512 -> four all-ones beats and overflow_o=1 for exactly one cycle. Then rst_ni=0 mid-beat2 -> beat_valid_o=0 and beat_idx_o=0 after the next edge.
